// File: rtl/ysyx_24090018_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_pkg
// Shared constants and types for the writeback unit.
//   ADDR_WIDTH : register address width (RV32E uses only the low 4 bits)
//   DATA_WIDTH : register data width
//   NREG       : number of architectural registers tracked by the scoreboard
//   src_e      : writeback source encoding, used by the round-robin arbiter
// ---------------------------------------------------------------------------
package ysyx_24090018_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam int NREG       = 16;

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_EXU = 1'b1
    } src_e;

endpackage

// File: rtl/ysyx_24090018_wb_arb.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_wb_arb
// Two-way round-robin arbiter between the LSU and EXU result channels.
// Grants are combinational in the valids and the last-granted flag, so a
// grant doubles as the handshake (a source is never granted while idle).
//   clk, rst_n          : clock, synchronous active-low reset
//   lsu_valid_i         : LSU requests writeback
//   exu_valid_i         : EXU requests writeback
//   lsu_gnt_o/exu_gnt_o : one-hot grant (both low when nobody is valid)
// ---------------------------------------------------------------------------
module ysyx_24090018_wb_arb
    import ysyx_24090018_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic lsu_valid_i,
    input  logic exu_valid_i,
    output logic lsu_gnt_o,
    output logic exu_gnt_o
);

    // Source that won the most recent grant. Resetting to EXU makes the
    // LSU the winner of the first tie.
    src_e last_q;
    src_e last_d;

    always_comb begin
        lsu_gnt_o = lsu_valid_i && (!exu_valid_i || (last_q == SRC_EXU));
        exu_gnt_o = exu_valid_i && !lsu_gnt_o;

        last_d = last_q;
        if (lsu_gnt_o) begin
            last_d = SRC_LSU;
        end else if (exu_gnt_o) begin
            last_d = SRC_EXU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= SRC_EXU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ysyx_24090018_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_wbu
// Writeback unit: accepts EXU/LSU results through a round-robin arbiter,
// registers the winner into the register-file write port, and keeps a
// per-register busy scoreboard that the IDU uses to stall on RAW/WAW.
//   clk, rst_n                  : clock, synchronous active-low reset
//   iss_valid_i/iss_wen_i       : instruction being issued, writes rd
//   iss_rd_i/iss_rs1_i/iss_rs2_i: its destination and sources
//   hazard_o                    : issue must stall this cycle (combinational)
//   exu_valid_i/rd/data, exu_ready_o : EXU result channel
//   lsu_valid_i/rd/data, lsu_ready_o : LSU result channel
//   wen_o/waddr_o/wdata_o       : register file write port (one cycle after
//                                 the handshake)
//   busy_o                      : scoreboard contents
// ---------------------------------------------------------------------------
module ysyx_24090018_wbu
    import ysyx_24090018_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid_i,
    input  logic                  iss_wen_i,
    input  logic [ADDR_WIDTH-1:0] iss_rd_i,
    input  logic [ADDR_WIDTH-1:0] iss_rs1_i,
    input  logic [ADDR_WIDTH-1:0] iss_rs2_i,
    output logic                  hazard_o,
    input  logic                  exu_valid_i,
    input  logic [ADDR_WIDTH-1:0] exu_rd_i,
    input  logic [DATA_WIDTH-1:0] exu_data_i,
    output logic                  exu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  lsu_ready_o,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [NREG-1:0]       busy_o
);

    localparam int IDX_W = $clog2(NREG);

    // ---------------- arbitration ----------------
    logic lsu_gnt;
    logic exu_gnt;
    logic hs;

    ysyx_24090018_wb_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lsu_valid_i (lsu_valid_i),
        .exu_valid_i (exu_valid_i),
        .lsu_gnt_o   (lsu_gnt),
        .exu_gnt_o   (exu_gnt)
    );

    assign lsu_ready_o = lsu_gnt;
    assign exu_ready_o = exu_gnt;
    assign hs          = lsu_gnt || exu_gnt;

    // ---------------- output stage ----------------
    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        sel_rd   = exu_gnt ? exu_rd_i   : lsu_rd_i;
        sel_data = exu_gnt ? exu_data_i : lsu_data_i;

        // Address/data track every accepted result, even x0 writes, so the
        // port shows the last thing retired; only the enable filters x0.
        wen_d   = hs && (sel_rd[IDX_W-1:0] != '0);
        waddr_d = hs ? sel_rd   : waddr_q;
        wdata_d = hs ? sel_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

    // ---------------- scoreboard ----------------
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            issue_set;

    // No bypass: a source reads as ready only once its busy bit has cleared,
    // which happens at the same edge the register file is written.
    assign hazard_o = iss_valid_i &&
                      (busy_q[iss_rs1_i[IDX_W-1:0]] ||
                       busy_q[iss_rs2_i[IDX_W-1:0]] ||
                       (iss_wen_i && busy_q[iss_rd_i[IDX_W-1:0]]));

    assign issue_set = iss_valid_i && iss_wen_i && !hazard_o &&
                       (iss_rd_i[IDX_W-1:0] != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_bit
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_set && (iss_rd_i[IDX_W-1:0] == IDX_W'(gi));
                assign clr_hit = wen_q && (waddr_q[IDX_W-1:0] == IDX_W'(gi));
                // A coincident set beats the clear.
                assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    // Upper address bits alias onto the low IDX_W bits for scoreboard lookup.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{iss_rd_i[ADDR_WIDTH-1:IDX_W],
                              iss_rs1_i[ADDR_WIDTH-1:IDX_W],
                              iss_rs2_i[ADDR_WIDTH-1:IDX_W]};

endmodule

// File: doc/ysyx_24090018_wbu.md
# ysyx_24090018_wbu

Writeback unit: collects results from the EXU and LSU over valid/ready handshakes, arbitrates them round-robin, and drives the register file write port (`wen`/`waddr`/`wdata`) through one register stage. It also keeps a per-register busy scoreboard, set at issue and cleared at writeback, so the IDU can stall on RAW/WAW hazards. It sits between the execute/memory stages and the 16-entry RV32E register file.

## Interface
- `ADDR_WIDTH`, 5, register address width
- `DATA_WIDTH`, 32, data width
- `NREG`, 16, architectural registers; index = `addr[3:0]`
- `clk`  in  1  clock, all state on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `iss_valid_i`  in  1  IDU presents an instruction for issue
- `iss_wen_i`  in  1  issuing instruction writes `rd`
- `iss_rd_i`, `iss_rs1_i`, `iss_rs2_i`  in  ADDR_WIDTH  destination / sources of issuing instruction
- `hazard_o`  out  1  issue must stall this cycle (combinational)
- `exu_valid_i`, `exu_rd_i`, `exu_data_i`  in  1 / ADDR_WIDTH / DATA_WIDTH  EXU result
- `exu_ready_o`  out  1  EXU result accepted this cycle
- `lsu_valid_i`, `lsu_rd_i`, `lsu_data_i`  in  1 / ADDR_WIDTH / DATA_WIDTH  LSU load result
- `lsu_ready_o`  out  1  LSU result accepted this cycle
- `wen_o`, `waddr_o`, `wdata_o`  out  1 / ADDR_WIDTH / DATA_WIDTH  register file write port
- `busy_o`  out  NREG  scoreboard, for debug/difftest

## Operation
- Arbitration: only one source valid → it is granted. Both valid → the source not granted last time is granted (round-robin flag `last`). After reset, LSU wins the first tie.
- `x_ready_o` = grant to source x. It depends combinationally on the valids and `last`. A source is never granted while its valid is low. A handshake is `x_valid_i && x_ready_o`.
- Sources must hold `rd`/`data` stable while valid and not ready.
- Accepted result (`rd`, `data`) is registered into the output stage.
    - `wen_o` = 1 iff a handshake occurred the previous cycle and `rd[3:0] != 0`.
    - `waddr_o`/`wdata_o` update on every handshake, including rd = 0, and hold otherwise.
- Scoreboard `busy[NREG-1:0]`; `busy[0]` is constant 0.
    - Set: `iss_valid_i && iss_wen_i && !hazard_o && iss_rd_i[3:0] != 0` sets `busy[rd]`.
    - Clear: `wen_o` high clears `busy[waddr_o]` at the same edge the RF writes.
    - Set and clear of the same index at the same edge: set wins. This only occurs for an illegal issue; it is defined for robustness.
- `hazard_o` = `iss_valid_i && (busy[rs1] || busy[rs2] || (iss_wen_i && busy[rd]))`. Indices are the low 4 bits. No bypass: a register becomes readable only after its busy bit clears.
- A result to a non-busy register is still written; the clear is a no-op. An address with bit 4 set aliases onto the low 4 bits (illegal in RV32E, not checked).

## Timing
- Reset values: `wen_o`=0, `waddr_o`=0, `wdata_o`=0, `busy_o`=0, `last`=EXU (so LSU wins first tie). Ready/hazard outputs follow combinationally.
- Reset asserted mid-operation: pending output write dropped, scoreboard cleared, no `wen_o` pulse in the cycle after reset is released.
- Handshake in cycle N → `wen_o` high in cycle N+1 → RF updated at end of N+1 → busy clears at the same edge → `hazard_o` for that register drops in N+2.
- Throughput: one result per cycle. The output stage never stalls, because the RF always accepts.
- Back-to-back ties alternate grants every cycle: LSU, EXU, LSU, …

## Structure
- Package `ysyx_24090018_pkg`: `ADDR_WIDTH`, `DATA_WIDTH`, `NREG`, source encoding `SRC_LSU`/`SRC_EXU`.
- Sub-module `ysyx_24090018_wb_arb`: 2-way round-robin arbiter holding `last`. Inputs: two valids. Outputs: two one-hot grants.
- Top holds the output register and the scoreboard.

## Test plan
- Reset, then EXU only: EXU rd=5, data=0xDEADBEEF accepted cycle 1 → `wen_o`=1, `waddr_o`=5, `wdata_o`=0xDEADBEEF in cycle 2. `wen_o`=0 in cycle 3.
- Both valid for 4 cycles, LSU rd=1..4 and EXU rd=6..9 → grants LSU, EXU, LSU, EXU. Each `wen_o` pulse is one cycle later, with matching addr/data.
- Scoreboard:
    - Issue rd=3 → `busy_o[3]`=1.
    - Issue with rs1=3 → `hazard_o`=1, no busy change.
    - EXU writes rd=3 in cycle N → `hazard_o`=0 in N+2.
- x0: issue rd=0 → busy unchanged. LSU result rd=0, data=0x1234 → `lsu_ready_o`=1, `wen_o` stays 0.
- WAW: rd=7 busy, issue with rd=7 and `iss_wen_i`=1 → `hazard_o`=1. With `iss_wen_i`=0 and rs1/rs2 ≠ 7 → `hazard_o`=0.
- Reset mid-flight: handshake in cycle N with `rst_n`=0 at the N+1 edge → no `wen_o` pulse, `busy_o`=0, first tie afterwards goes to LSU.
